branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/mips_bp_pkg.sv | 23 ++
 rtl/bru_sat_counter.sv | 35 +++
 rtl/branch_resolve_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mips_bp_pkg.sv
// Shared definitions for the branch predictor / resolution slice.
// Contents:
//   bru_state_e  - resolution FSM states (RUN, REDIR)
//   IDX_W_DEF    - default PHT index width
//   NUM_SLOTS    - instructions resolved per cycle (dual issue)
//   CNT_W        - performance counter width
//   popcount2    - number of set bits in a two-slot mask
package mips_bp_pkg;

    localparam int unsigned IDX_W_DEF = 7;
    localparam int unsigned NUM_SLOTS = 2;
    localparam int unsigned CNT_W     = 32;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } bru_state_e;

    function automatic logic [1:0] popcount2(input logic [NUM_SLOTS-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/bru_sat_counter.sv
// Saturating up-counter used for the branch performance counters.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears the count
//   inc   - amount to add this cycle (0..2)
//   count - current count; sticks at all-ones instead of wrapping
module bru_sat_counter
    import mips_bp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + {{(CNT_W - 1){1'b0}}, inc};
        count_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Dual-slot branch resolution in decode. Latches the fetch-stage prediction
// alongside the instruction pair, compares the predicted next PC against the
// resolved one, redirects fetch on a mismatch and emits per-slot predictor
// updates plus branch / mispredict performance counters.
// Ports:
//   clk, rst                 - clock and asynchronous active-high reset
//   stallF, stallD           - fetch / decode stall
//   flushD_ext               - external decode flush (also cancels resolution)
//   PCF, PC_predF            - fetch PC and predicted target
//   pred_takenF              - predicted taken per slot ([0]=PC, [1]=PC+4)
//   branchD1/2, pcsrcD1/2    - slot is a branch / slot resolved taken
//   PCBranchD1/2             - resolved targets
//   redirect, flush_fd       - fetch redirect, kill F/D latch
//   redirect_pc              - correct next PC
//   upd_valid, upd_taken     - predictor update strobe and outcome per slot
//   upd_idx1/2, upd_target1/2- predictor update indices and targets
//   cnt_branch, cnt_mispred  - saturating performance counters
module branch_resolve_unit
    import mips_bp_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallF,
    input  logic                 stallD,
    input  logic                 flushD_ext,
    input  logic [31:0]          PCF,
    input  logic [31:0]          PC_predF,
    input  logic [NUM_SLOTS-1:0] pred_takenF,
    input  logic                 branchD1,
    input  logic                 branchD2,
    input  logic                 pcsrcD1,
    input  logic                 pcsrcD2,
    input  logic [31:0]          PCBranchD1,
    input  logic [31:0]          PCBranchD2,
    output logic                 redirect,
    output logic                 flush_fd,
    output logic [31:0]          redirect_pc,
    output logic [NUM_SLOTS-1:0] upd_valid,
    output logic [NUM_SLOTS-1:0] upd_taken,
    output logic [IDX_W-1:0]     upd_idx1,
    output logic [IDX_W-1:0]     upd_idx2,
    output logic [31:0]          upd_target1,
    output logic [31:0]          upd_target2,
    output logic [CNT_W-1:0]     cnt_branch,
    output logic [CNT_W-1:0]     cnt_mispred
);

    // F/D latch
    logic                 vd_q;
    logic [31:0]          pcd_q;
    logic [31:0]          pc_predd_q;
    logic [NUM_SLOTS-1:0] pred_takend_q;

    bru_state_e state_q, state_d;

    logic [31:0]          pc_plus8;
    logic [31:0]          npred;
    logic [31:0]          nact;
    logic                 resolve;
    logic                 mispred;
    logic [NUM_SLOTS-1:0] upd_valid_d;

    logic [31:0]          redirect_pc_q;
    logic [NUM_SLOTS-1:0] upd_valid_q;
    logic [NUM_SLOTS-1:0] upd_taken_q;
    logic [IDX_W-1:0]     upd_idx1_q;
    logic [IDX_W-1:0]     upd_idx2_q;
    logic [31:0]          upd_target1_q;
    logic [31:0]          upd_target2_q;

    // Flush wins over capture; a stalled decode keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vd_q          <= 1'b0;
            pcd_q         <= '0;
            pc_predd_q    <= '0;
            pred_takend_q <= '0;
        end else if (flush_fd || flushD_ext) begin
            vd_q <= 1'b0;
        end else if (!stallF && !stallD) begin
            vd_q          <= 1'b1;
            pcd_q         <= PCF;
            pc_predd_q    <= PC_predF;
            pred_takend_q <= pred_takenF;
        end
    end

    always_comb begin
        pc_plus8 = pcd_q + 32'd8;
        npred    = (pred_takend_q != '0) ? pc_predd_q : pc_plus8;
        // Slot 1 taken makes slot 2 wrong-path, so it takes priority.
        nact     = pcsrcD1 ? PCBranchD1 : (pcsrcD2 ? PCBranchD2 : pc_plus8);
        // An external flush in the same cycle invalidates the decode pair.
        resolve  = (state_q == RUN) && vd_q && !flushD_ext && !stallD;
        mispred  = resolve && (npred != nact);
        upd_valid_d = resolve ? {branchD2 && !pcsrcD1, branchD1} : '0;
    end

    always_comb begin
        state_d  = state_q;
        redirect = 1'b0;
        flush_fd = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mispred) begin
                    state_d = REDIR;
                end
            end
            REDIR: begin
                redirect = 1'b1;
                flush_fd = 1'b1;
                if (!stallF) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            redirect_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (mispred) begin
                redirect_pc_q <= nact;
            end
        end
    end

    // Update strobe is a one-cycle pulse; payload holds between resolutions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid_q   <= '0;
            upd_taken_q   <= '0;
            upd_idx1_q    <= '0;
            upd_idx2_q    <= '0;
            upd_target1_q <= '0;
            upd_target2_q <= '0;
        end else begin
            upd_valid_q <= upd_valid_d;
            if (resolve) begin
                upd_taken_q   <= {pcsrcD2, pcsrcD1};
                upd_idx1_q    <= pcd_q[IDX_W-1:0];
                upd_idx2_q    <= pcd_q[IDX_W-1:0] + IDX_W'(4);
                upd_target1_q <= PCBranchD1;
                upd_target2_q <= PCBranchD2;
            end
        end
    end

    // Counters advance on the same edge that raises the update / redirect.
    bru_sat_counter u_cnt_branch (
        .clk   (clk),
        .rst   (rst),
        .inc   (popcount2(upd_valid_d)),
        .count (cnt_branch)
    );

    bru_sat_counter u_cnt_mispred (
        .clk   (clk),
        .rst   (rst),
        .inc   ({1'b0, mispred}),
        .count (cnt_mispred)
    );

    assign redirect_pc = redirect_pc_q;
    assign upd_valid   = upd_valid_q;
    assign upd_taken   = upd_taken_q;
    assign upd_idx1    = upd_idx1_q;
    assign upd_idx2    = upd_idx2_q;
    assign upd_target1 = upd_target1_q;
    assign upd_target2 = upd_target2_q;

endmodule
